neurocore_lsk_framer: RTL and testbench
=======================================

// Module: neurocore_lsk_framer
// PURPOSE
//  Downstream of the neurocore field sensor: buffers 3-bit commands (cmd_in/cmd_valid) in a small FIFO.
//  Sends each one over the inductive back-channel as a Manchester-coded frame on lsk_ctrl (LSK MOSFET gate).
//  Absorbs command bursts while a frame is in flight; reports occupancy and overflow.
// PARAMETERS
//  BIT_DIV     8  clocks per Manchester half-bit (>=1)
//  FIFO_DEPTH  4  command slots (power of 2, >=2)
//  GAP_BITS    2  idle bit-periods enforced after every frame
// PORTS
//  clk         in   1  single clock, all logic rising-edge
//  rst         in   1  synchronous, active-high reset
//  enable      in   1  permit starting new frames
//  cmd_in      in   3  command code
//  cmd_valid   in   1  one-cycle strobe; no back-pressure upstream
//  ovf_clr     in   1  clear sticky overflow
//  lsk_ctrl    out  1  Manchester line to MOSFET
//  lsk_tx      out  1  high for every cycle of a frame (not gap)
//  busy        out  1  FSM not IDLE
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
//  overflow    out  1  sticky: a command was dropped
// BEHAVIOUR
//  Reset: all outputs 0; FIFO flushed; FSM IDLE. Reset mid-frame aborts it; lsk_ctrl=0 from the next edge.
//  Frame: preamble 1,0,1,0; cmd[2],cmd[1],cmd[0]; parity p=^cmd (even over cmd+p). 8 bits, MSB first.
//  Manchester: '1' = high half then low half; '0' = low then high. Each half = BIT_DIV clocks.
//  Frame length is 16*BIT_DIV cycles.
//  FSM IDLE -> SEND when enable && fifo non-empty. On that edge: pop head; load shift reg; clear counters.
//  SEND -> GAP after the last half-bit. GAP lasts GAP_BITS*2*BIT_DIV cycles with lsk_ctrl=0 and lsk_tx=0.
//  GAP -> IDLE. GAP_BITS=0 returns to IDLE directly.
//  Latency: cmd_valid sampled at edge E0 with FSM IDLE and FIFO empty.
//    fifo_level=1 after E0. SEND entered at E1. lsk_tx=1 and first half-bit on lsk_ctrl from E1 to E1+16*BIT_DIV.
//  lsk_ctrl, lsk_tx registered; lsk_ctrl=0 in IDLE and GAP.
//  FIFO push when cmd_valid. Full && no pop: command dropped, overflow<=1, contents unchanged.
//  Full && pop same edge: push accepted, level unchanged. Order strictly FIFO.
//  ovf_clr clears overflow. ovf_clr and a new drop on the same edge: overflow stays 1 (set wins).
//  enable deassert mid-frame: the frame and its gap complete; no new frame starts. The FIFO keeps accepting.
//  Counters saturate-free: half-bit counter wraps 0..BIT_DIV-1; bit index 0..FRAME_BITS-1.
// CONFIGURATION
//  `LSK_PARITY_EN defined: parity bit sent, FRAME_BITS=8.
//  `LSK_PARITY_EN undefined: no parity bit, FRAME_BITS=7, frame = 14*BIT_DIV cycles; otherwise identical.
// STRUCTURE
//  neurocore_lsk_pkg: state enum {IDLE,SEND,GAP}; LSK_PREAMBLE=4'b1010; FRAME_BITS constant (macro-dependent).
//  Sub-module neurocore_cmd_fifo: synchronous FIFO, DEPTH param; push/pop/full/empty/level.
//  Framer FSM + Manchester serializer live in this file.
// TESTING
//  1 BIT_DIV=2, enable=1, cmd 3'b101 -> lsk_tx high 32 cycles.
//    lsk_ctrl pairs: 10 01 10 01 10 01 10 01 (bits 1010 101 0). lsk_tx low 8 gap cycles, busy low after.
//  2 FIFO_DEPTH=4, five cmds 1..5 on consecutive cycles starting the cycle after cmd 0 is accepted.
//    -> cmd0 transmits first; 1,2,3,4 queue; cmd 5 drops. overflow=1, and 0,1,2,3,4 emerge in order.
//  3 FIFO full, cmd_valid on the exact SEND-entry edge -> push accepted, fifo_level stays 4, overflow stays 0.
//  4 rst asserted mid-preamble -> next cycle lsk_ctrl=0, lsk_tx=0, fifo_level=0, busy=0.
//    No frame follows until a new cmd_valid.
//  5 enable dropped during frame of cmd 3'b011, another cmd queued.
//    -> current frame + gap finish; queued cmd held (level=1) until enable=1, then sent.
//  6 `LSK_PARITY_EN undefined, cmd 3'b111, BIT_DIV=1 -> 14 lsk_tx cycles.
//    Pattern 10 01 10 01 10 10 10; ovf_clr clears a prior overflow.

Source files
------------

// File: rtl/neurocore_lsk_pkg.sv
// Shared types and constants for the neurocore LSK back-channel framer.
// Build option: define LSK_PARITY_EN to append an even-parity bit to every frame.
package neurocore_lsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } lsk_state_e;

    localparam logic [3:0] LSK_PREAMBLE = 4'b1010;

`ifdef LSK_PARITY_EN
    localparam int FRAME_BITS = 8;
`else
    localparam int FRAME_BITS = 7;
`endif

    // Frame word, MSB transmitted first. Without parity only the top seven bits go out.
    function automatic logic [7:0] build_frame(input logic [2:0] cmd);
        return {LSK_PREAMBLE, cmd, ^cmd};
    endfunction

endpackage

// File: rtl/neurocore_lsk_framer_if.sv
// Command/status bundle between the field-sensor side and the LSK framer.
// master drives commands and control; slave (the framer) drives the line and status.
interface neurocore_lsk_framer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               enable;
    logic [2:0]         cmd_in;
    logic               cmd_valid;
    logic               ovf_clr;
    logic               lsk_ctrl;
    logic               lsk_tx;
    logic               busy;
    logic [LEVEL_W-1:0] fifo_level;
    logic               overflow;

    modport master (
        output enable, cmd_in, cmd_valid, ovf_clr,
        input  lsk_ctrl, lsk_tx, busy, fifo_level, overflow
    );

    modport slave (
        input  enable, cmd_in, cmd_valid, ovf_clr,
        output lsk_ctrl, lsk_tx, busy, fifo_level, overflow
    );

endinterface

// File: rtl/neurocore_cmd_fifo.sv
// Synchronous command FIFO with a combinational head. A push into a full FIFO
// is accepted only when a pop happens on the same edge; otherwise it is ignored.
module neurocore_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; level gates every read, so stale slots are never observed.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/neurocore_lsk_framer.sv
// Neurocore LSK framer: queues 3-bit commands and sends each as a Manchester
// frame (preamble 1010, cmd MSB first, optional parity) on the LSK MOSFET gate.
// Build option: LSK_PARITY_EN adds the parity bit (8-bit frames instead of 7).
module neurocore_lsk_framer
    import neurocore_lsk_pkg::*;
#(
    parameter int BIT_DIV    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    neurocore_lsk_framer_if.slave         bus
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int HALF_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int GAP_CYC = GAP_BITS * 2 * BIT_DIV;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BIT_DIV - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    lsk_state_e          state;
    logic [7:0]          shreg;
    logic [HALF_W-1:0]   half_cnt;
    logic                second_half;
    logic [2:0]          bit_idx;
    logic [GAP_W-1:0]    gap_cnt;
    logic                lsk_ctrl_q;
    logic                lsk_tx_q;
    logic                busy_q;
    logic                overflow_q;

    logic [2:0]          head;
    logic [7:0]          frame_word;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LEVEL_W-1:0]  level;
    logic                start;
    logic                drop;

    // A frame starts only from IDLE; the pop happens on the same edge SEND is entered.
    assign start      = (state == IDLE) && bus.enable && !fifo_empty;
    assign drop       = bus.cmd_valid && fifo_full && !start;
    assign frame_word = build_frame(head);

    neurocore_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .pop   (start),
        .din   (bus.cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Framer FSM and Manchester serializer: one bit = high/low halves for '1', low/high for '0'.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            half_cnt    <= '0;
            second_half <= 1'b0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            lsk_ctrl_q  <= 1'b0;
            lsk_tx_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SEND;
                        shreg       <= frame_word;
                        half_cnt    <= '0;
                        second_half <= 1'b0;
                        bit_idx     <= '0;
                        lsk_ctrl_q  <= frame_word[7];
                        lsk_tx_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                SEND: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!second_half) begin
                            second_half <= 1'b1;
                            lsk_ctrl_q  <= ~shreg[7];
                        end else if (bit_idx == BIT_LAST) begin
                            second_half <= 1'b0;
                            lsk_ctrl_q  <= 1'b0;
                            lsk_tx_q    <= 1'b0;
                            if (GAP_CYC == 0) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            second_half <= 1'b0;
                            bit_idx     <= bit_idx + 3'd1;
                            shreg       <= {shreg[6:0], 1'b0};
                            lsk_ctrl_q  <= shreg[6];
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    lsk_ctrl_q <= 1'b0;
                    lsk_tx_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a drop on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)              overflow_q <= 1'b0;
        else if (drop)        overflow_q <= 1'b1;
        else if (bus.ovf_clr) overflow_q <= 1'b0;
    end

    assign bus.lsk_ctrl   = lsk_ctrl_q;
    assign bus.lsk_tx     = lsk_tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_neurocore_lsk_framer.sv
// Directed testbench for neurocore_lsk_framer. Two instances share the clock:
// dut_a (BIT_DIV=2) and dut_b (BIT_DIV=1), both FIFO_DEPTH=4, GAP_BITS=2.
// Expected frames follow LSK_PARITY_EN the same way the design does.
module tb_neurocore_lsk_framer;

`ifdef LSK_PARITY_EN
    localparam int TB_FB = 8;
    localparam logic [15:0] EXP_101 = 16'b10_01_10_01_10_01_10_01;
    localparam logic [15:0] EXP_111 = 16'b10_01_10_01_10_10_10_10;
`else
    localparam int TB_FB = 7;
    localparam logic [15:0] EXP_101 = 16'b10_01_10_01_10_01_10_00;
    localparam logic [15:0] EXP_111 = 16'b10_01_10_01_10_10_10_00;
`endif

    logic clk;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   miscompares;

    neurocore_lsk_framer_if #(.FIFO_DEPTH(4)) if_a ();
    neurocore_lsk_framer_if #(.FIFO_DEPTH(4)) if_b ();

    neurocore_lsk_framer #(.BIT_DIV(2), .FIFO_DEPTH(4), .GAP_BITS(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    neurocore_lsk_framer #(.BIT_DIV(1), .FIFO_DEPTH(4), .GAP_BITS(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? if_b.lsk_tx : if_a.lsk_tx;
    endfunction

    function automatic logic get_ctrl(input bit sel);
        return sel ? if_b.lsk_ctrl : if_a.lsk_ctrl;
    endfunction

    // Manchester half-bit pattern of one frame, MSB-aligned in 16 bits.
    function automatic logic [15:0] exp_frame(input logic [2:0] c);
        logic [7:0]  b;
        logic [15:0] h;
        b = {4'b1010, c, ^c};
        h = '0;
        for (int i = 0; i < TB_FB; i++) begin
            h[15 - 2*i] = b[7 - i];
            h[14 - 2*i] = ~b[7 - i];
        end
        return h;
    endfunction

    task automatic apply_reset(input bit sel);
        if (sel) begin
            rst_b = 1'b1; if_b.enable = 1'b0; if_b.cmd_valid = 1'b0; if_b.ovf_clr = 1'b0; if_b.cmd_in = '0;
        end else begin
            rst_a = 1'b1; if_a.enable = 1'b0; if_a.cmd_valid = 1'b0; if_a.ovf_clr = 1'b0; if_a.cmd_in = '0;
        end
        tick();
        tick();
        if (sel) rst_b = 1'b0;
        else     rst_a = 1'b0;
    endtask

    // Waits for the next frame start, records one sample per half-bit, and checks the
    // half-bit pattern plus that lsk_tx stays high exactly for the frame and the line is steady per half.
    task automatic capture_frame(input bit sel, input int bd, input logic [15:0] exp,
                                 input string name, output int latency);
        int          waited;
        logic [15:0] obs;
        bit          shape_ok;
        latency = -1;
        waited  = 0;
        while (get_tx(sel) === 1'b1 && waited < 400) begin tick(); waited++; end
        waited = 0;
        while (get_tx(sel) !== 1'b1 && waited < 400) begin tick(); waited++; end
        vectors++;
        if (get_tx(sel) !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: no frame within 400 cycles, lsk_tx=%b expected 1", name, get_tx(sel));
            return;
        end
        latency  = waited;
        obs      = '0;
        shape_ok = 1'b1;
        for (int h = 0; h < 2*TB_FB; h++) begin
            for (int k = 0; k < bd; k++) begin
                if (k == 0) obs[15 - h] = get_ctrl(sel);
                else if (get_ctrl(sel) !== obs[15 - h]) shape_ok = 1'b0;
                if (get_tx(sel) !== 1'b1) shape_ok = 1'b0;
                tick();
            end
        end
        if (get_tx(sel) !== 1'b0 || get_ctrl(sel) !== 1'b0) shape_ok = 1'b0;
        if (obs !== exp || !shape_ok) begin
            miscompares++;
            $display("FAIL %s: halves=%b shape_ok=%0d, expected halves=%b shape_ok=1",
                     name, obs, shape_ok, exp);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.enable = 1'b1; if_a.cmd_valid = 1'b1; if_a.cmd_in = 3'b101; if_a.ovf_clr = 1'b0;
        if_b.enable = 1'b1; if_b.cmd_valid = 1'b1; if_b.cmd_in = 3'b010; if_b.ovf_clr = 1'b0;
        tick();
        tick();
        vectors++;
        if ({if_a.lsk_ctrl, if_a.lsk_tx, if_a.busy, if_a.overflow, if_a.fifo_level} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_a: outputs=%b expected 0000000",
                     {if_a.lsk_ctrl, if_a.lsk_tx, if_a.busy, if_a.overflow, if_a.fifo_level});
        end
        vectors++;
        if ({if_b.lsk_ctrl, if_b.lsk_tx, if_b.busy, if_b.overflow, if_b.fifo_level} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_b: outputs=%b expected 0000000",
                     {if_b.lsk_ctrl, if_b.lsk_tx, if_b.busy, if_b.overflow, if_b.fifo_level});
        end
        if_a.cmd_valid = 1'b0; if_b.cmd_valid = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_single_frame();
        int lat;
        bit gap_ok;
        apply_reset(0);
        if_a.enable = 1'b1;
        if_a.cmd_in = 3'b101; if_a.cmd_valid = 1'b1;
        tick();
        if_a.cmd_valid = 1'b0;
        vectors++;
        if (if_a.fifo_level !== 3'd1) begin
            miscompares++; $display("FAIL t1_level_after_e0: got %0d expected 1", if_a.fifo_level);
        end
        vectors++;
        if (if_a.lsk_tx !== 1'b0 || if_a.busy !== 1'b0) begin
            miscompares++; $display("FAIL t1_idle_at_e0: tx=%b busy=%b expected 0 0", if_a.lsk_tx, if_a.busy);
        end
        capture_frame(0, 2, EXP_101, "t1_frame_101", lat);
        vectors++;
        if (lat != 1) begin
            miscompares++; $display("FAIL t1_latency: got %0d expected 1", lat);
        end
        vectors++;
        if (if_a.fifo_level !== 3'd0) begin
            miscompares++; $display("FAIL t1_level_after_frame: got %0d expected 0", if_a.fifo_level);
        end
        gap_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (if_a.lsk_tx !== 1'b0 || if_a.lsk_ctrl !== 1'b0 || if_a.busy !== 1'b1) gap_ok = 1'b0;
            tick();
        end
        vectors++;
        if (!gap_ok) begin
            miscompares++; $display("FAIL t1_gap: gap_ok=%0d expected 1", gap_ok);
        end
        vectors++;
        if (if_a.busy !== 1'b0) begin
            miscompares++; $display("FAIL t1_busy_after_gap: got %b expected 0", if_a.busy);
        end
    endtask

    task automatic test_overflow_order();
        int lat;
        apply_reset(0);
        if_a.enable = 1'b1;
        fork
            begin
                for (int c = 0; c < 5; c++)
                    capture_frame(0, 2, exp_frame(3'(c)), $sformatf("t2_order_cmd%0d", c), lat);
            end
            begin
                if_a.cmd_in = 3'd0; if_a.cmd_valid = 1'b1;
                tick();
                for (int c = 1; c <= 5; c++) begin
                    if_a.cmd_in = 3'(c);
                    tick();
                end
                if_a.cmd_valid = 1'b0;
                vectors++;
                if (if_a.overflow !== 1'b1 || if_a.fifo_level !== 3'd4) begin
                    miscompares++;
                    $display("FAIL t2_drop: overflow=%b level=%0d expected 1 4", if_a.overflow, if_a.fifo_level);
                end
            end
        join
    endtask

    task automatic test_full_pop_same_edge();
        int lat;
        apply_reset(0);
        for (int c = 1; c <= 4; c++) begin
            if_a.cmd_in = 3'(c); if_a.cmd_valid = 1'b1;
            tick();
        end
        if_a.cmd_in = 3'd7; if_a.enable = 1'b1;
        tick();
        if_a.cmd_valid = 1'b0;
        vectors++;
        if (if_a.fifo_level !== 3'd4 || if_a.overflow !== 1'b0 || if_a.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_full_pop: level=%0d overflow=%b busy=%b expected 4 0 1",
                     if_a.fifo_level, if_a.overflow, if_a.busy);
        end
        capture_frame(0, 2, exp_frame(3'd2), "t3_next_cmd2", lat);
        capture_frame(0, 2, exp_frame(3'd3), "t3_next_cmd3", lat);
        capture_frame(0, 2, exp_frame(3'd4), "t3_next_cmd4", lat);
        capture_frame(0, 2, exp_frame(3'd7), "t3_pushed_cmd7", lat);
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        int tx_seen;
        apply_reset(0);
        if_a.enable = 1'b1;
        if_a.cmd_in = 3'd5; if_a.cmd_valid = 1'b1;
        tick();
        if_a.cmd_in = 3'd6;
        tick();
        if_a.cmd_valid = 1'b0;
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        vectors++;
        if ({if_a.lsk_ctrl, if_a.lsk_tx, if_a.busy, if_a.fifo_level} !== 6'd0) begin
            miscompares++;
            $display("FAIL t4_reset_abort: ctrl=%b tx=%b busy=%b level=%0d expected 0 0 0 0",
                     if_a.lsk_ctrl, if_a.lsk_tx, if_a.busy, if_a.fifo_level);
        end
        rst_a = 1'b0;
        tx_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (if_a.lsk_tx !== 1'b0 || if_a.busy !== 1'b0) tx_seen++;
            tick();
        end
        vectors++;
        if (tx_seen != 0) begin
            miscompares++; $display("FAIL t4_no_frame_after_reset: active cycles=%0d expected 0", tx_seen);
        end
        if_a.cmd_in = 3'd2; if_a.cmd_valid = 1'b1;
        tick();
        if_a.cmd_valid = 1'b0;
        capture_frame(0, 2, exp_frame(3'd2), "t4_frame_after_reset", lat);
    endtask

    task automatic test_enable_hold();
        int lat;
        int tx_seen;
        apply_reset(0);
        if_a.enable = 1'b1;
        fork
            capture_frame(0, 2, exp_frame(3'b011), "t5_frame_011", lat);
            begin
                if_a.cmd_in = 3'b011; if_a.cmd_valid = 1'b1;
                tick();
                if_a.cmd_in = 3'b110;
                tick();
                if_a.cmd_valid = 1'b0;
                vectors++;
                if (if_a.fifo_level !== 3'd1 || if_a.lsk_tx !== 1'b1) begin
                    miscompares++;
                    $display("FAIL t5_queued: level=%0d tx=%b expected 1 1", if_a.fifo_level, if_a.lsk_tx);
                end
                tick(); tick(); tick();
                if_a.enable = 1'b0;
            end
        join
        tx_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (if_a.lsk_tx !== 1'b0) tx_seen++;
            tick();
        end
        vectors++;
        if (tx_seen != 0 || if_a.busy !== 1'b0 || if_a.fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL t5_held: tx_cycles=%0d busy=%b level=%0d expected 0 0 1",
                     tx_seen, if_a.busy, if_a.fifo_level);
        end
        if_a.enable = 1'b1;
        capture_frame(0, 2, exp_frame(3'b110), "t5_frame_110", lat);
        vectors++;
        if (lat != 1) begin
            miscompares++; $display("FAIL t5_resume_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_no_parity_ovf_clr();
        int lat;
        apply_reset(1);
        for (int c = 1; c <= 5; c++) begin
            if_b.cmd_in = 3'(c); if_b.cmd_valid = 1'b1;
            tick();
        end
        if_b.cmd_valid = 1'b0;
        vectors++;
        if (if_b.overflow !== 1'b1 || if_b.fifo_level !== 3'd4) begin
            miscompares++;
            $display("FAIL t6_overflow_set: overflow=%b level=%0d expected 1 4", if_b.overflow, if_b.fifo_level);
        end
        if_b.ovf_clr = 1'b1;
        tick();
        if_b.ovf_clr = 1'b0;
        vectors++;
        if (if_b.overflow !== 1'b0) begin
            miscompares++; $display("FAIL t6_ovf_clr: got %b expected 0", if_b.overflow);
        end
        if_b.ovf_clr = 1'b1; if_b.cmd_valid = 1'b1; if_b.cmd_in = 3'd6;
        tick();
        if_b.ovf_clr = 1'b0; if_b.cmd_valid = 1'b0;
        vectors++;
        if (if_b.overflow !== 1'b1 || if_b.fifo_level !== 3'd4) begin
            miscompares++;
            $display("FAIL t6_set_wins: overflow=%b level=%0d expected 1 4", if_b.overflow, if_b.fifo_level);
        end
        apply_reset(1);
        if_b.enable = 1'b1;
        if_b.cmd_in = 3'b111; if_b.cmd_valid = 1'b1;
        tick();
        if_b.cmd_valid = 1'b0;
        capture_frame(1, 1, EXP_111, "t6_frame_111_bd1", lat);
        vectors++;
        if (lat != 1) begin
            miscompares++; $display("FAIL t6_latency: got %0d expected 1", lat);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.enable = 1'b0; if_a.cmd_in = '0; if_a.cmd_valid = 1'b0; if_a.ovf_clr = 1'b0;
        if_b.enable = 1'b0; if_b.cmd_in = '0; if_b.cmd_valid = 1'b0; if_b.ovf_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow_order();
        test_full_pop_same_edge();
        test_reset_mid_frame();
        test_enable_hold();
        test_no_parity_ovf_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
